// File: rtl/vp_sequencer.sv
// vp_sequencer: five-state instruction sequencer driving ALU lane controls and write strobes
module vp_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         op_code,
  output logic               sel0,
  output logic               sel1,
  output logic               sel2,
  output logic               rf_we_a,
  output logic               rf_we_b,
  output logic               dmem_we,
  output logic               busy,
  output logic               done,
  output logic [15:0]        instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMWAIT} state_t;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_LDR  = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_DPRO = 3'b111;
  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [2:0]         dec_op;
  logic               exec, retire, stop;
  assign dec_op      = imem_data[14:12];
  assign exec        = state_q == EXEC;
  assign retire      = (exec && op_q != OP_LDR) || state_q == MEMWAIT;
  assign stop        = op_q == OP_HALT || &pc_q || abort || abort_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op_code     = op_q;
  assign {sel0, sel1, sel2} = sel_q;
  assign rf_we_a     = exec && (op_q == OP_ADD || op_q == OP_MUL || op_q == OP_MOV || op_q == OP_DPRO);
  assign rf_we_b     = state_q == MEMWAIT;
  assign dmem_we     = exec && op_q == OP_STR;
  assign busy        = state_q != IDLE;
  assign done        = retire && stop;
  assign instr_count = cnt_q;
  // next-state, decode latching and retire bookkeeping; abort seen while busy is held until retire
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    abort_d = (state_q != IDLE && abort) ? 1'b1 : abort_q;
    case (state_q)
      IDLE: if (start) begin
        pc_d    = '0;
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = FETCH;
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        instr_d = imem_data;
        op_d    = dec_op;
        sel_d   = dec_op == OP_LDR ? 3'b010 :
                  dec_op == OP_STR ? 3'b110 :
                  (dec_op == OP_ADD || dec_op == OP_MUL || dec_op == OP_MOV) ? 3'b001 : 3'b000;
        state_d = EXEC;
      end
      EXEC:    state_d = op_q == OP_LDR ? MEMWAIT : state_q;
      MEMWAIT: state_d = state_q;
      default: state_d = IDLE;
    endcase
    if (retire) begin
      cnt_d   = &cnt_q ? cnt_q : cnt_q + 16'd1;
      pc_d    = op_q == OP_HALT ? pc_q : pc_q + 1'b1;
      state_d = stop ? IDLE : FETCH;
      abort_d = 1'b0;
    end
  end
  // state registers, cleared asynchronously so pending strobes vanish on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_vp_sequencer.sv
// tb_vp_sequencer: directed programs with a strobe-event scoreboard and cycle-exact checks
module tb_vp_sequencer;
  localparam logic [2:0] ADD = 3'b000, MUL = 3'b001, NOP = 3'b010, HALT = 3'b011;
  localparam logic [2:0] LDR = 3'b100, STR = 3'b101, MOV = 3'b110, DPRO = 3'b111;
  typedef struct packed {logic [2:0] we; logic [2:0] sel; logic dn;} ev_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, start, abort, start_w, abort_w;
  logic [7:0]  imem_addr;
  logic [59:0] imem_data, instr;
  logic [2:0]  op_code;
  logic        sel0, sel1, sel2, rf_we_a, rf_we_b, dmem_we, busy, done;
  logic [15:0] instr_count;
  logic [1:0]  imem_addr_w;
  logic [59:0] imem_data_w, instr_w;
  logic [2:0]  op_code_w;
  logic        sel0_w, sel1_w, sel2_w, rf_we_a_w, rf_we_b_w, dmem_we_w, busy_w, done_w;
  logic [15:0] instr_count_w;
  logic [59:0] mem [256];
  logic [59:0] mem_w [4];
  ev_t         exp_q [$];
  ev_t         mon_g, mon_e;
  int          n_cmp = 0, n_fail = 0;
  logic [59:0] w0;
  vp_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .op_code(op_code), .sel0(sel0), .sel1(sel1),
    .sel2(sel2), .rf_we_a(rf_we_a), .rf_we_b(rf_we_b), .dmem_we(dmem_we), .busy(busy),
    .done(done), .instr_count(instr_count)
  );
  vp_sequencer #(.PC_W(2), .INSTR_W(60)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .abort(abort_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .instr(instr_w), .op_code(op_code_w), .sel0(sel0_w), .sel1(sel1_w),
    .sel2(sel2_w), .rf_we_a(rf_we_a_w), .rf_we_b(rf_we_b_w), .dmem_we(dmem_we_w), .busy(busy_w),
    .done(done_w), .instr_count(instr_count_w)
  );
  always @(posedge clk) begin
    imem_data   <= mem[imem_addr];
    imem_data_w <= mem_w[imem_addr_w];
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [59:0] mk(logic [2:0] op);
    logic [59:0] w;
    w = 60'({$urandom(), $urandom()});
    w[14:12] = op;
    return w;
  endfunction
  function automatic ev_t ev(logic [2:0] we, logic [2:0] sel, logic dn);
    return '{we: we, sel: sel, dn: dn};
  endfunction
  always @(negedge clk) begin
    if (!reset && (rf_we_a || rf_we_b || dmem_we || done)) begin
      mon_g = ev({rf_we_a, rf_we_b, dmem_we}, {sel0, sel1, sel2}, done);
      check("strobe_onehot", 64'($countones(mon_g.we) <= 1), 1);
      if (exp_q.size() == 0) check("sb_unexpected", mon_g, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("sb_event", mon_g, mon_e);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_idle(int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask
  task automatic fill(logic [2:0] op);
    for (int i = 0; i < 256; i++) mem[i] = mk(op);
  endtask
  initial begin
    int nd;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_w = 1'b0; abort_w = 1'b0;
    fill(NOP);
    for (int i = 0; i < 4; i++) mem_w[i] = mk(MOV);
    #1;
    check("rst_ctrl", {busy, done, rf_we_a, rf_we_b, dmem_we, sel0, sel1, sel2, op_code}, 0);
    check("rst_instr", instr, 0);
    check("rst_pc_cnt", {imem_addr, instr_count}, 0);
    check("rst_w", {busy_w, done_w, imem_addr_w, instr_count_w}, 0);
    tick(); tick();
    reset = 1'b0;
    // ADD, HALT
    w0 = mk(ADD); mem[0] = w0; mem[1] = mk(HALT);
    exp_q.push_back(ev(3'b100, 3'b001, 1'b0));
    exp_q.push_back(ev(3'b000, 3'b000, 1'b1));
    pulse_start();
    check("add_fetch", {busy, imem_addr}, {1'b1, 8'd0});
    tick();
    check("add_decode_nostrobe", {rf_we_a, rf_we_b, dmem_we}, 0);
    tick();
    check("add_exec", {rf_we_a, op_code}, {1'b1, ADD});
    check("add_instr", instr, w0);
    tick();
    check("add_after", {rf_we_a, imem_addr, instr_count}, {1'b0, 8'd1, 16'd1});
    tick(); tick();
    check("halt_done_c6", {done, busy}, 2'b11);
    tick();
    check("halt_idle_c7", {busy, done, instr_count}, {2'b00, 16'd2});
    // LDR, STR, HALT
    fill(NOP);
    mem[0] = mk(LDR); mem[1] = mk(STR); mem[2] = mk(HALT);
    exp_q.push_back(ev(3'b010, 3'b010, 1'b0));
    exp_q.push_back(ev(3'b001, 3'b110, 1'b0));
    exp_q.push_back(ev(3'b000, 3'b000, 1'b1));
    pulse_start(); tick(); tick();
    check("ldr_exec_nostrobe", {rf_we_a, rf_we_b, dmem_we, sel0, sel1, sel2}, 6'b000010);
    tick();
    check("ldr_memwait_c4", rf_we_b, 1);
    tick(); tick(); tick();
    check("str_exec_c7", {dmem_we, sel0, sel1}, 3'b111);
    wait_idle(10);
    check("ldr_prog_cnt", instr_count, 3);
    // abort during DPRO
    fill(NOP);
    mem[0] = mk(DPRO); mem[1] = mk(ADD);
    exp_q.push_back(ev(3'b100, 3'b000, 1'b1));
    pulse_start(); tick();
    abort = 1'b1;
    tick();
    check("abort_exec", {rf_we_a, sel2, done}, 3'b101);
    abort = 1'b0;
    tick();
    check("abort_idle", {busy, instr_count}, {1'b0, 16'd1});
    tick(); tick(); tick();
    check("abort_nofetch", {busy, op_code, imem_addr}, {1'b0, DPRO, 8'd1});
    // reset in EXEC of STR
    fill(NOP);
    mem[0] = mk(STR); mem[1] = mk(HALT);
    pulse_start(); tick(); tick();
    check("str_before_rst", dmem_we, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_ctrl", {dmem_we, rf_we_a, rf_we_b, busy, done, sel0, sel1, sel2, op_code}, 0);
    check("rst_mid_state", {instr, imem_addr, instr_count}, 0);
    tick();
    reset = 1'b0;
    exp_q.push_back(ev(3'b001, 3'b110, 1'b0));
    exp_q.push_back(ev(3'b000, 3'b000, 1'b1));
    pulse_start();
    check("restart_pc0", {busy, imem_addr}, {1'b1, 8'd0});
    wait_idle(12);
    check("restart_cnt", instr_count, 2);
    // start while busy
    fill(NOP);
    mem[0] = mk(MOV); mem[1] = mk(MOV); mem[2] = mk(HALT);
    exp_q.push_back(ev(3'b100, 3'b001, 1'b0));
    exp_q.push_back(ev(3'b100, 3'b001, 1'b0));
    exp_q.push_back(ev(3'b000, 3'b000, 1'b1));
    pulse_start(); tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_c5", {imem_addr, instr_count}, {8'd1, 16'd1});
    tick(); tick();
    check("busy_start_c7", {imem_addr, instr_count}, {8'd2, 16'd2});
    wait_idle(12);
    check("busy_start_cnt", instr_count, 3);
    // PC_W=2 wrap, then start+abort together
    for (int r = 0; r < 2; r++) begin
      start_w = 1'b1;
      abort_w = 1'(r);
      tick();
      start_w = 1'b0;
      abort_w = 1'b0;
      check("wrap_busy", busy_w, 1);
      nd = 0;
      for (int i = 0; i < 20; i++) begin
        if (done_w) nd++;
        tick();
      end
      check("wrap_done_once", nd, 1);
      check("wrap_end", {busy_w, imem_addr_w, instr_count_w}, {1'b0, 2'd0, 16'd4});
    end
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vp_sequencer.md
VP_SEQUENCER -- requirements
Module: vp_sequencer

Interface
REQ-001 Parameter PC_W, default 8, instruction address width.
REQ-002 Parameter INSTR_W, default 60, instruction word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins program execution at address 0 when IDLE.
REQ-006 abort  input  1  stops execution at the next instruction boundary.
REQ-007 imem_addr  output  PC_W  instruction memory address (= pc).
REQ-008 imem_data  input  INSTR_W  instruction memory read data; valid one cycle after imem_addr is presented.
REQ-009 instr  output  INSTR_W  latched current instruction; drives register-address fields [11:0].
REQ-010 op_code  output  3  latched instr[14:12], to the four ALU lanes.
REQ-011 sel0, sel1, sel2  output  1 each  datapath mux selects.
REQ-012 rf_we_a, rf_we_b, dmem_we  output  1 each  register-file port A/B and data-memory write strobes.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on program completion.
REQ-015 instr_count  output  16  number of instructions retired since last start, saturating at 16'hFFFF.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEMWAIT.
REQ-017 IDLE: on start, pc<=0, instr_count<=0, go to FETCH; otherwise remain.
REQ-018 FETCH: imem_addr=pc; next state DECODE (1 cycle).
REQ-019 DECODE: instr<=imem_data; op_code, sel0-2 registered from imem_data[14:12] per REQ-022; next state EXEC.
REQ-020 EXEC: write strobes asserted per REQ-022 for exactly this cycle, except LDR; LDR goes to MEMWAIT with no strobe in EXEC.
REQ-021 MEMWAIT (LDR only): rf_we_b=1 for this single cycle (registered data-memory read); then retire.
REQ-022 Decode table (op: we_a/we_b/dmem_we/sel0/sel1/sel2): 000 ADD 1/0/0/0/0/1; 001 MUL 1/0/0/0/0/1; 100 LDR 0/1/0/0/1/0; 101 STR 0/0/1/1/1/0; 110 MOV 1/0/0/0/0/1; 111 DPRO 1/0/0/0/0/0; 010 NOP all 0; 011 HALT all 0.
REQ-023 Retire (end of EXEC, or MEMWAIT for LDR): pc<=pc+1, instr_count increments (saturating), next state FETCH.
REQ-024 HALT opcode SHALL retire (count increments), pulse done in its EXEC cycle, go to IDLE; pc not incremented.
REQ-025 pc at 2**PC_W-1 retiring a non-HALT instruction SHALL wrap to 0, pulse done, go to IDLE.
REQ-026 abort SHALL be sampled at retire; if high, instruction completes its strobes, done pulses, FSM goes to IDLE.
REQ-027 Latency: 3 cycles per instruction, 4 for LDR; no strobe asserted in FETCH, DECODE or IDLE.
REQ-028 op_code, sel0-2 and instr SHALL hold stable from DECODE until the next DECODE.
REQ-029 start while busy SHALL be ignored; start and abort together in IDLE: start wins, abort ignored.
REQ-030 At most one of rf_we_a, rf_we_b, dmem_we SHALL be high in any cycle.

Reset
REQ-031 reset SHALL force state IDLE, pc=0, instr=0, op_code=0, sel0-2=0, all strobes 0, busy=0, done=0, instr_count=0, immediately and independent of clk.
REQ-032 reset mid-instruction SHALL suppress any pending strobe; no write occurs after reset assertion.

Verification
REQ-033 Program {ADD, HALT}, start -> rf_we_a high 1 cycle at cycle 3, done at cycle 6, instr_count=2, busy low at cycle 7.
REQ-034 Program {LDR, STR, HALT} -> rf_we_b in MEMWAIT (cycle 4), dmem_we with sel0=sel1=1 at cycle 7, instr_count=3.
REQ-035 PC_W=2, four MOV instructions, no HALT -> pc wraps 3->0, done pulses once, instr_count=4.
REQ-036 abort asserted during DECODE of a DPRO -> rf_we_a pulses with sel2=0, then done, IDLE; next instruction never fetched.
REQ-037 reset asserted in EXEC of STR -> dmem_we drops same cycle, all outputs at reset values; subsequent start restarts at pc=0.
REQ-038 start pulsed while busy -> ignored; pc and instr_count continue unchanged.
